// File: rtl/fetch_mt_pkg.sv
// Shared fetch types and the round-robin picker used by issue and output selection.
// Pure types/functions; no state, no latency.
// No flow control of its own.
package fetch_mt_pkg;

  localparam int MAX_THREADS = 32;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } fetch_state_t;

  // First requester at or after 'start', wrapping over n threads.
  // Returns 'start' when nothing requests; callers qualify with |req.
  function automatic int rr_pick(input logic [MAX_THREADS-1:0] req,
                                 input int start, input int n);
    int sel;
    int idx;
    logic [MAX_THREADS-1:0] sh;
    sel = start;
    for (int i = n - 1; i >= 0; i--) begin
      idx = (start + i) % n;
      sh  = req >> idx;
      if (sh[0]) sel = idx;
    end
    return sel;
  endfunction

endpackage

// File: rtl/fetch_mt_fifo.sv
// Per-thread instruction queue: circular buffer with synchronous clear and occupancy count.
// Push visible at head the cycle after the write edge; head is read combinationally.
// No internal backpressure: the parent guarantees no push when full and no pop when empty.
module fetch_fifo
  import fetch_mt_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   push,
  input  fetch_entry_t           push_data,
  input  logic                   pop,
  output fetch_entry_t           head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t    mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;

  // Pointer and occupancy tracking; clear wins over a same-cycle push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage needs no reset; only occupied slots are ever observed.
  always_ff @(posedge clk) begin
    if (push && !clr) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_mt.sv
// Multi-thread fetch: per-thread PC/epoch/queue, one outstanding imem request, round-robin issue and output.
// Request registered 1 cycle after issue; enqueued entry visible on out_* 1 cycle after the response.
// Issue stalls when a thread's queue plus in-flight slot is full; out_ready low simply holds the queues.
module fetch_mt
  import fetch_mt_pkg::*;
#(
  parameter int          NUM_THREADS = 2,
  parameter int          IQ_DEPTH    = 8,
  parameter logic [31:0] RESET_PC    = 32'h1eceb000,
  parameter int          TID_W       = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_THREADS-1:0] thread_en,
  input  logic                   redirect_valid,
  input  logic [TID_W-1:0]       redirect_tid,
  input  logic [31:0]            redirect_pc,
  output logic                   imem_req_valid,
  input  logic                   imem_req_ready,
  output logic [31:0]            imem_addr,
  input  logic                   imem_resp_valid,
  input  logic [31:0]            imem_rdata,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [TID_W-1:0]       out_tid,
  output logic [31:0]            out_pc,
  output logic [31:0]            out_instr,
  output logic [NUM_THREADS-1:0] iq_empty
);

  localparam int CNT_W = $clog2(IQ_DEPTH) + 1;

  fetch_state_t                        state;
  logic [TID_W-1:0]                    req_tid;
  logic [31:0]                         req_addr;
  logic                                req_epoch;
  logic [TID_W-1:0]                    issue_ptr;
  logic [TID_W-1:0]                    out_ptr;

  logic [NUM_THREADS-1:0][31:0]        pc;
  logic [NUM_THREADS-1:0]              epoch;
  logic [NUM_THREADS-1:0]              reserved;
  logic [NUM_THREADS-1:0][CNT_W-1:0]   count;
  fetch_entry_t                        head [NUM_THREADS];

  logic [NUM_THREADS-1:0]              redir_hit;
  logic [NUM_THREADS-1:0]              elig;
  logic [NUM_THREADS-1:0]              nonempty;
  logic [NUM_THREADS-1:0]              push;
  logic [NUM_THREADS-1:0]              pop;
  logic                                issue_slot;
  logic                                do_issue;
  logic                                resp_fire;
  logic                                resp_fresh;
  logic                                pop_fire;
  logic [TID_W-1:0]                    issue_sel;
  logic [TID_W-1:0]                    out_sel;
  fetch_entry_t                        resp_entry;

  function automatic logic [TID_W-1:0] next_tid(input logic [TID_W-1:0] t);
    return TID_W'((int'(t) + 1) % NUM_THREADS);
  endfunction

  // Eligibility, response routing and output arbitration for this cycle.
  always_comb begin
    redir_hit = '0;
    elig      = '0;
    nonempty  = '0;
    push      = '0;
    pop       = '0;
    for (int t = 0; t < NUM_THREADS; t++) begin
      redir_hit[t] = redirect_valid && (int'(redirect_tid) == t);
      elig[t]      = thread_en[t] && !redir_hit[t] &&
                     ((int'(count[t]) + int'(reserved[t])) < IQ_DEPTH);
      nonempty[t]  = (count[t] != '0) && !redir_hit[t];
    end
    issue_slot = (state == IDLE) || ((state == WAIT) && imem_resp_valid);
    do_issue   = issue_slot && (|elig);
    issue_sel  = TID_W'(rr_pick(MAX_THREADS'(elig), int'(issue_ptr), NUM_THREADS));
    resp_fire  = (state == WAIT) && imem_resp_valid;
    // A redirect landing with the response kills it even though the epoch flips only at the edge.
    resp_fresh = resp_fire && (req_epoch == epoch[req_tid]) && !redir_hit[req_tid];
    resp_entry.pc    = req_addr;
    resp_entry.instr = imem_rdata;
    out_valid  = |nonempty;
    out_sel    = TID_W'(rr_pick(MAX_THREADS'(nonempty), int'(out_ptr), NUM_THREADS));
    pop_fire   = out_valid && out_ready;
    for (int t = 0; t < NUM_THREADS; t++) begin
      push[t] = resp_fresh && (req_tid == TID_W'(t));
      pop[t]  = pop_fire && (out_sel == TID_W'(t));
    end
  end

  // Per-thread PC, epoch and in-flight reservation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int t = 0; t < NUM_THREADS; t++) pc[t] <= RESET_PC;
      epoch    <= '0;
      reserved <= '0;
    end else begin
      for (int t = 0; t < NUM_THREADS; t++) begin
        if (redir_hit[t]) begin
          pc[t]    <= redirect_pc;
          epoch[t] <= ~epoch[t];
        end else if (do_issue && (issue_sel == TID_W'(t))) begin
          pc[t] <= pc[t] + 32'd4;
        end
        // Set after clear so a thread re-issuing on its own response cycle stays reserved.
        if (do_issue && (issue_sel == TID_W'(t))) reserved[t] <= 1'b1;
        else if (resp_fire && (req_tid == TID_W'(t))) reserved[t] <= 1'b0;
      end
    end
  end

  // Request FSM with latched request fields, plus both round-robin pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      req_tid   <= '0;
      req_addr  <= '0;
      req_epoch <= 1'b0;
      issue_ptr <= '0;
      out_ptr   <= '0;
    end else begin
      if (pop_fire) out_ptr <= next_tid(out_sel);
      case (state)
        IDLE, WAIT: begin
          if (issue_slot) begin
            if (do_issue) begin
              state     <= REQ;
              req_tid   <= issue_sel;
              req_addr  <= pc[issue_sel];
              req_epoch <= epoch[issue_sel];
              issue_ptr <= next_tid(issue_sel);
            end else begin
              state <= IDLE;
            end
          end
        end
        REQ:     if (imem_req_ready) state <= WAIT;
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_THREADS; g++) begin : g_iq
    fetch_fifo #(.DEPTH(IQ_DEPTH)) u_iq (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (redir_hit[g]),
      .push      (push[g]),
      .push_data (resp_entry),
      .pop       (pop[g]),
      .head      (head[g]),
      .count     (count[g])
    );
    assign iq_empty[g] = (count[g] == '0);
  end

  assign imem_req_valid = (state == REQ);
  assign imem_addr      = req_addr;
  assign out_tid        = out_valid ? out_sel : '0;
  assign out_pc         = out_valid ? head[out_sel].pc : 32'd0;
  assign out_instr      = out_valid ? head[out_sel].instr : 32'd0;

endmodule

// File: tb/tb_fetch_mt.sv
module tb_fetch_mt;

  localparam int NT = 2;

  logic          clk;
  logic          rst_n;
  logic [NT-1:0] thread_en;
  logic          redirect_valid;
  logic [0:0]    redirect_tid;
  logic [31:0]   redirect_pc;
  logic          imem_req_valid;
  logic          imem_req_ready;
  logic [31:0]   imem_addr;
  logic          imem_resp_valid;
  logic [31:0]   imem_rdata;
  logic          out_valid;
  logic          out_ready;
  logic [0:0]    out_tid;
  logic [31:0]   out_pc;
  logic [31:0]   out_instr;
  logic [NT-1:0] iq_empty;

  fetch_mt #(.NUM_THREADS(2), .IQ_DEPTH(8), .RESET_PC(32'h1eceb000)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .thread_en       (thread_en),
    .redirect_valid  (redirect_valid),
    .redirect_tid    (redirect_tid),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_addr       (imem_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_rdata      (imem_rdata),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_tid         (out_tid),
    .out_pc          (out_pc),
    .out_instr       (out_instr),
    .iq_empty        (iq_empty)
  );

  typedef struct {
    logic [0:0]  tid;
    logic [31:0] pc;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          acc;
  int          lat;
  int          pend_cnt;
  logic        ready_en;
  logic        pend;
  logic [31:0] pend_addr;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'hdead0013;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic expect_out(input int tid, input logic [31:0] pc);
    exp_t e;
    e.tid = 1'(tid);
    e.pc  = pc;
    sb.push_back(e);
  endtask

  // One cycle: advance to the falling edge and run the imem responder.
  task automatic step();
    @(negedge clk);
    imem_resp_valid = 1'b0;
    if (pend) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        imem_resp_valid = 1'b1;
        imem_rdata      = instr_of(pend_addr);
        pend            = 1'b0;
      end
    end
    imem_req_ready = ready_en;
    if (rst_n && imem_req_valid && imem_req_ready) begin
      pend      = 1'b1;
      pend_cnt  = lat;
      pend_addr = imem_addr;
      acc++;
    end
  endtask

  task automatic do_reset();
    rst_n           = 1'b0;
    thread_en       = '0;
    out_ready       = 1'b0;
    redirect_valid  = 1'b0;
    ready_en        = 1'b1;
    lat             = 1;
    pend            = 1'b0;
    imem_resp_valid = 1'b0;
    acc             = 0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic wait_acc(input int n, input string name);
    for (int i = 0; i < 200 && acc < n; i++) step();
    check(name, acc, n);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 300 && (sb.size() != 0 || out_valid); i++) step();
    check(name, sb.size(), 0);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_req_valid"}, 32'(imem_req_valid), 32'd0);
    check({tag, "_addr"},      imem_addr,            32'd0);
    check({tag, "_out_valid"}, 32'(out_valid),       32'd0);
    check({tag, "_out_tid"},   32'(out_tid),         32'd0);
    check({tag, "_out_pc"},    out_pc,               32'd0);
    check({tag, "_out_instr"}, out_instr,            32'd0);
    check({tag, "_iq_empty"},  32'(iq_empty),        32'd3);
  endtask

  // Monitor: every accepted output is compared against the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out actual=tid%0d pc=%h required=none", out_tid, out_pc);
        end else begin
          e = sb.pop_front();
          check("out_tid",   32'(out_tid), 32'(e.tid));
          check("out_pc",    out_pc,       e.pc);
          check("out_instr", out_instr,    instr_of(e.pc));
        end
      end
    end
  end

  initial begin
    rst_n           = 1'b0;
    thread_en       = '0;
    redirect_valid  = 1'b0;
    redirect_tid    = '0;
    redirect_pc     = '0;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_rdata      = '0;
    out_ready       = 1'b0;
    ready_en        = 1'b1;
    lat             = 1;
    pend            = 1'b0;
    pend_cnt        = 0;
    pend_addr       = '0;
    acc             = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check_idle("reset");

    // Both threads alternate from the reset PC.
    thread_en = 2'b11;
    out_ready = 1'b1;
    expect_out(0, 32'h1eceb000);
    expect_out(1, 32'h1eceb000);
    expect_out(0, 32'h1eceb004);
    expect_out(1, 32'h1eceb004);
    wait_acc(4, "t1_reqs");
    thread_en = '0;
    drain("t1_drain");

    // Full queue stops issue; one pop frees exactly one slot.
    do_reset();
    thread_en = 2'b01;
    for (int i = 0; i < 9; i++) expect_out(0, 32'h1eceb000 + 32'(4 * i));
    wait_acc(8, "t2_fill");
    repeat (20) step();
    check("t2_no_ninth", acc, 8);
    check("t2_req_idle", 32'(imem_req_valid), 32'd0);
    check("t2_iq_full", 32'(iq_empty), 32'd2);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    wait_acc(9, "t2_refill");
    repeat (10) step();
    check("t2_one_more", acc, 9);
    thread_en = '0;
    out_ready = 1'b1;
    drain("t2_drain");

    // Redirect while a request is in WAIT: its response is dropped.
    do_reset();
    lat       = 3;
    thread_en = 2'b01;
    out_ready = 1'b1;
    expect_out(0, 32'h1eceb000);
    expect_out(0, 32'h1eceb004);
    expect_out(0, 32'h1eceb100);
    wait_acc(3, "t3_reqs");
    thread_en = '0;
    step();
    redirect_valid = 1'b1;
    redirect_tid   = 1'b0;
    redirect_pc    = 32'h1eceb100;
    step();
    redirect_valid = 1'b0;
    thread_en      = 2'b01;
    wait_acc(4, "t3_new_req");
    check("t3_iq0_empty", 32'(iq_empty[0]), 32'd1);
    check("t3_addr", imem_addr, 32'h1eceb100);
    thread_en = '0;
    drain("t3_drain");

    // Stalled request stays stable through a redirect and its data is discarded.
    do_reset();
    ready_en  = 1'b0;
    thread_en = 2'b01;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && !imem_req_valid; i++) step();
    check("t4_req_seen", 32'(imem_req_valid), 32'd1);
    for (int k = 0; k < 5; k++) begin
      check("t4_addr_stable", imem_addr, 32'h1eceb000);
      if (k == 1) begin
        redirect_valid = 1'b1;
        redirect_tid   = 1'b0;
        redirect_pc    = 32'h1eceb200;
      end
      if (k == 2) redirect_valid = 1'b0;
      step();
    end
    ready_en = 1'b1;
    expect_out(0, 32'h1eceb200);
    wait_acc(2, "t4_reqs");
    check("t4_new_addr", imem_addr, 32'h1eceb200);
    thread_en = '0;
    drain("t4_drain");

    // Disabled thread issues nothing but its queue still drains.
    do_reset();
    thread_en = 2'b10;
    expect_out(1, 32'h1eceb000);
    expect_out(1, 32'h1eceb004);
    expect_out(1, 32'h1eceb008);
    wait_acc(3, "t5_reqs");
    thread_en = '0;
    repeat (10) step();
    check("t5_no_issue", acc, 3);
    check("t5_iq1_held", 32'(iq_empty[1]), 32'd0);
    out_ready = 1'b1;
    drain("t5_drain");
    check("t5_empty", 32'(iq_empty), 32'd3);

    // Reset in WAIT, then a stray response in IDLE is ignored.
    do_reset();
    lat       = 3;
    thread_en = 2'b01;
    wait_acc(1, "t6_req");
    step();
    rst_n     = 1'b0;
    thread_en = '0;
    pend      = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
    imem_resp_valid = 1'b1;
    imem_rdata      = instr_of(32'h1eceb000);
    step();
    step();
    check_idle("t6");
    lat       = 1;
    acc       = 0;
    thread_en = 2'b11;
    out_ready = 1'b1;
    expect_out(0, 32'h1eceb000);
    expect_out(1, 32'h1eceb000);
    wait_acc(2, "t6_reqs");
    thread_en = '0;
    drain("t6_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_mt.md
# fetch_mt

Multi-thread instruction fetch unit that replaces the single-context fetch stage in front of decode. It holds one PC and one instruction queue per hardware thread and issues one instruction-memory request at a time, choosing among threads round-robin. Each queued instruction is tagged with an epoch so that responses made stale by a redirect are dropped. It sits between the I-cache request/response port and decode; the hardware scheduler steers it through per-thread enables, and the ROB/branch logic steers it through per-thread redirects.

## Interface
- NUM_THREADS, 2: hardware threads; ≥1. TID_W = max(1, $clog2(NUM_THREADS)).
- IQ_DEPTH, 8: entries per thread queue; power of two, ≥2.
- RESET_PC, 32'h1eceb000: PC loaded into every thread at reset.
- clk in 1: clock.
- rst_n in 1: reset, asynchronous, active-low.
- thread_en in NUM_THREADS: scheduler enable per thread.
- redirect_valid in 1, redirect_tid in TID_W, redirect_pc in 32: flush or jump of one thread.
- imem_req_valid out 1, imem_req_ready in 1, imem_addr out 32: request channel.
- imem_resp_valid in 1, imem_rdata in 32: response channel. Responses come back in order, at most one outstanding.
- out_valid out 1, out_ready in 1, out_tid out TID_W, out_pc out 32, out_instr out 32: channel to decode.
- iq_empty out NUM_THREADS: per-thread empty flags.

## Operation
- Per-thread state: pc, epoch bit, FIFO count, reserved bit. Global state: FSM {IDLE, REQ, WAIT}, plus latched req_tid, req_addr, req_epoch.
- Eligibility of thread t: thread_en[t]; count[t]+reserved[t] < IQ_DEPTH; and not (redirect_valid && redirect_tid==t) this cycle.
- Issue: happens in IDLE, or in WAIT on the cycle the response arrives. The round-robin pick starts after the last issued tid. The unit latches tid, pc[t] and epoch[t], sets reserved[t], sets pc[t] += 4 (mod 2^32) and moves to REQ. If no thread is eligible, the FSM goes to or stays in IDLE.
- REQ: imem_req_valid=1. imem_addr=req_addr stays stable until imem_req_ready. On ready the FSM moves to WAIT. The request is never withdrawn, including when its thread is redirected.
- WAIT: on imem_resp_valid, reserved[req_tid] clears. If req_epoch==epoch[req_tid], {req_addr, imem_rdata} is enqueued into FIFO req_tid. Otherwise the response is discarded.
- Redirect: pc[tid] <= redirect_pc, epoch[tid] toggles, FIFO[tid] is cleared, all on the next edge. An outstanding request for that thread becomes stale.
- Output: round-robin over non-empty FIFOs, excluding the tid being redirected this cycle. out_* show that FIFO's head. A pop occurs on out_valid && out_ready, and the output pointer then advances.
- Disabled thread: issues no new requests. Its FIFO still drains, and an outstanding non-stale response is still enqueued.
- Simultaneous events:
  - Redirect and response for the same tid: the response is dropped.
  - Redirect and pop for the same tid: impossible, because that tid is masked from output.
  - Push and pop on the same FIFO: count unchanged.
  - Reserved slot: guarantees that an enqueue never overflows.
- Reset values:
  - imem_req_valid=0, imem_addr=0, out_valid=0, out_tid=0, out_pc=0, out_instr=0.
  - iq_empty all 1.
  - All pc=RESET_PC, epochs=0, counts=0, FSM=IDLE, both round-robin pointers at thread 0.
  - Reset mid-request: all state is discarded. A response arriving after reset while in IDLE is ignored.

## Timing
- imem_req_valid and imem_addr are registered; they assert the cycle after issue.
- Request-to-response latency is arbitrary, ≥1 cycle after acceptance.
- Sustained throughput is one instruction per 2 cycles when imem responds 1 cycle after acceptance.
- Enqueue to out_valid: 1 cycle (FIFO head is registered). Output signals are driven combinationally from FIFO heads.
- Redirect: the thread can issue from redirect_pc on the cycle after the redirect edge, provided the FSM is free.

## Structure
- rv32i_types gains fetch_entry_t {pc[31:0], instr[31:0]} and fetch_state_t {IDLE, REQ, WAIT}.
- One sub-module, fetch_fifo: parametrised DEPTH, synchronous clear, count output. It is instantiated NUM_THREADS times.
- A round-robin picker function is shared by the issue and output selection.

## Test plan
- Reset, both threads enabled, imem 1-cycle ready/resp: out sequence is T0 0x1eceb000, T1 0x1eceb000, T0 0x1eceb004, T1 0x1eceb004.
- Hold out_ready=0 with only T0 enabled: exactly 8 requests issue, count=8, imem_req_valid stays 0 afterwards. One pop then triggers exactly one new request.
- Redirect T0 to 0x1eceb100 while its request at 0x1eceb008 is in WAIT: that response is dropped, FIFO0 is empty, and the next T0 output pc is 0x1eceb100.
- Hold imem_req_ready=0 for 5 cycles and redirect the pending thread: imem_addr stays stable, the request completes, and its data is discarded.
- Deassert thread_en[1] with 3 entries queued: T1 issues no requests, and all 3 entries still drain.
- Assert rst_n=0 in WAIT, then pulse resp_valid in IDLE after reset: nothing is enqueued, all outputs return to reset values, and PCs are 0x1eceb000.
